// File: rtl/mul_div_sequencer_if.sv
// Handshake and result bundle between the EX stage and the mul/div engine.
// The pipeline side drives the request and reads back result and stall.
interface mul_div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [XLEN-1:0] result;
    logic            result_valid;
    logic            busy;
    logic            stall;

    modport master (
        output start, flush, func3, operand_a, operand_b,
        input  result, result_valid, busy, stall
    );

    modport slave (
        input  start, flush, func3, operand_a, operand_b,
        output result, result_valid, busy, stall
    );
endinterface

// File: rtl/mul_div_sequencer.sv
// Multi-cycle RV32M multiply/divide engine for the EX stage.
// Signed operations run on magnitudes; the sign is restored in FIX.
//
// state | meaning
// IDLE  | waiting for start; latches operands on an accepted start
// CALC  | one shift-add / restoring-divide step per cycle, XLEN steps
// FIX   | sign correction and half / quotient / remainder select
// DONE  | result_valid pulse, then back to IDLE
module mul_div_sequencer #(
    parameter int XLEN = 32
) (
    input logic             CLK,
    input logic             RESET,
    mul_div_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              busy_q;
    logic [2:0]        func3_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   mag_b_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  count_q;

    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_result;
    logic              accept;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    assign accept = bus.start && (state == IDLE) && !bus.flush;

    // Operand decode: signedness, magnitudes and the two divide fast paths.
    always_comb begin
        is_div      = bus.func3[2];
        a_signed    = (bus.func3 != 3'b011) && (bus.func3 != 3'b101) && (bus.func3 != 3'b111);
        b_signed    = a_signed && (bus.func3 != 3'b010);
        sign_a      = a_signed && bus.operand_a[XLEN-1];
        sign_b      = b_signed && bus.operand_b[XLEN-1];
        mag_a       = sign_a ? ({XLEN{1'b0}} - bus.operand_a) : bus.operand_a;
        mag_b       = sign_b ? ({XLEN{1'b0}} - bus.operand_b) : bus.operand_b;
        div_zero    = is_div && (bus.operand_b == '0);
        div_ovf     = is_div && !bus.func3[0]
                      && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.operand_b == '1);
        fast        = div_zero || div_ovf;
        // Overflow DIV returns the dividend itself; REM of either case follows func3[1].
        fast_result = div_zero ? (bus.func3[1] ? bus.operand_a : '1)
                               : (bus.func3[1] ? '0 : bus.operand_a);
    end

    // Iteration step and final sign fix-up, both derived from hi_q/lo_q.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        // The remainder stays below the divisor, so bit XLEN of this
        // difference is set exactly when the trial subtract borrows.
        div_diff  = div_shift - {1'b0, mag_b_q};
        prod_fix  = (sign_a_q ^ sign_b_q) ? ({(2*XLEN){1'b0}} - {hi_q, lo_q}) : {hi_q, lo_q};
        quo_fix   = (sign_a_q ^ sign_b_q) ? ({XLEN{1'b0}} - lo_q) : lo_q;
        rem_fix   = sign_a_q ? ({XLEN{1'b0}} - hi_q) : hi_q;
        case (func3_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Next-state logic; flush always wins and returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
            CALC:    if (count_q == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    // State register with registered busy flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt == CALC) || (state_nxt == FIX);
        end
    end

    // Datapath: operand latch, iteration, and result update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            func3_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_b_q  <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        func3_q  <= bus.func3;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        hi_q     <= '0;
                        lo_q     <= mag_a;
                        mag_b_q  <= mag_b;
                        count_q  <= CNT_W'(XLEN - 1);
                        if (fast) result_q <= fast_result;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        if (func3_q[2]) begin
                            hi_q <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                            lo_q <= {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                        end else begin
                            hi_q <= mul_sum[XLEN:1];
                            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                        end
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.flush) result_q <= fix_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.result       = result_q;
    assign bus.result_valid = (state == DONE);
    assign bus.busy         = busy_q;
    assign bus.stall        = accept || busy_q;
endmodule
